// File: rtl/decode_stage.sv
// RV32 decode stage: registers IF/ID into an ID/EX bundle, holds the 2R1W register file,
// handles the stall handshake, flush and load-use bubbles. Define ID_BYPASS_EN for regfile write-through.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int RAW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_id_valid,
  input  logic [31:0]     if_id_ir,
  input  logic [XLEN-1:0] if_id_npc,
  output logic            id_ready,
  input  logic            flush,
  input  logic            ex_ready,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_ex_valid,
  output logic [XLEN-1:0] id_ex_npc,
  output logic [31:0]     id_ex_ir,
  output logic [XLEN-1:0] id_ex_rs1_val,
  output logic [XLEN-1:0] id_ex_rs2_val,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [4:0]      id_ex_rd,
  output logic [2:0]      id_ex_fmt
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd6;

  logic [XLEN-1:0] regs_reg [NREGS];
  logic [NREGS-1:0] we_vec;
  logic [4:0]       rd_idx [2];

  logic            valid_reg;
  logic [XLEN-1:0] npc_reg, rs1_reg, rs2_reg, imm_reg;
  logic [31:0]     ir_reg;
  logic [4:0]      rd_reg;
  logic [2:0]      fmt_reg;

  logic [2:0]      fmt_next;
  logic [31:0]     imm32_next;
  logic            advance, hazard, load_bundle;

  // Entry 0 never gets a write strobe, so it stays at its reset value of zero.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_we
      assign we_vec[gi] = (gi != 0) && wb_we && (wb_rd == 5'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we_vec[i]) regs_reg[i] <= wb_data;
      end
    end
  end

  assign rd_idx[0] = if_id_ir[19:15];
  assign rd_idx[1] = if_id_ir[24:20];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [XLEN-1:0] val;
      always_comb begin
        val = '0;
        if (rd_idx[gi] != 5'd0 && {27'd0, rd_idx[gi]} < 32'(NREGS)) begin
`ifdef ID_BYPASS_EN
          if (wb_we && wb_rd == rd_idx[gi]) val = wb_data;
          else val = regs_reg[rd_idx[gi][RAW-1:0]];
`else
          val = regs_reg[rd_idx[gi][RAW-1:0]];
`endif
        end
      end
    end
  endgenerate

  always_comb begin
    fmt_next   = FMT_ILL;
    imm32_next = '0;
    case (if_id_ir[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        fmt_next   = FMT_I;
        imm32_next = {{20{if_id_ir[31]}}, if_id_ir[31:20]};
      end
      7'b0100011: begin
        fmt_next   = FMT_S;
        imm32_next = {{20{if_id_ir[31]}}, if_id_ir[31:25], if_id_ir[11:7]};
      end
      7'b1100011: begin
        fmt_next   = FMT_B;
        imm32_next = {{19{if_id_ir[31]}}, if_id_ir[31], if_id_ir[7],
                      if_id_ir[30:25], if_id_ir[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        fmt_next   = FMT_U;
        imm32_next = {if_id_ir[31:12], 12'b0};
      end
      7'b1101111: begin
        fmt_next   = FMT_J;
        imm32_next = {{11{if_id_ir[31]}}, if_id_ir[31], if_id_ir[19:12],
                      if_id_ir[20], if_id_ir[30:21], 1'b0};
      end
      7'b0110011: fmt_next = FMT_R;
      default:    fmt_next = FMT_ILL;
    endcase
  end

  // A load in ID/EX whose rd feeds the incoming instruction costs exactly one bubble.
  assign advance     = ex_ready | ~valid_reg;
  assign hazard      = valid_reg && (ir_reg[6:0] == 7'b0000011) && (rd_reg != 5'd0) &&
                       ((rd_reg == rd_idx[0]) || (rd_reg == rd_idx[1])) && if_id_valid;
  assign id_ready    = flush | (advance & ~hazard);
  assign load_bundle = advance & if_id_valid & ~hazard;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= 1'b0;
      npc_reg   <= '0;
      ir_reg    <= '0;
      rs1_reg   <= '0;
      rs2_reg   <= '0;
      imm_reg   <= '0;
      rd_reg    <= '0;
      fmt_reg   <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (load_bundle) begin
      valid_reg <= 1'b1;
      npc_reg   <= if_id_npc;
      ir_reg    <= if_id_ir;
      rs1_reg   <= g_rd[0].val;
      rs2_reg   <= g_rd[1].val;
      imm_reg   <= XLEN'(signed'(imm32_next));
      rd_reg    <= if_id_ir[11:7];
      fmt_reg   <= fmt_next;
    end else if (advance) begin
      valid_reg <= 1'b0;
    end
  end

  assign id_ex_valid   = valid_reg;
  assign id_ex_npc     = npc_reg;
  assign id_ex_ir      = ir_reg;
  assign id_ex_rs1_val = rs1_reg;
  assign id_ex_rs2_val = rs2_reg;
  assign id_ex_imm     = imm_reg;
  assign id_ex_rd      = rd_reg;
  assign id_ex_fmt     = fmt_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed cases plus random traffic against a behavioural model,
// with a second RV32E (NREGS=16) instance sharing the same inputs.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_id_valid;
  logic [31:0] if_id_ir, if_id_npc;
  logic        flush, ex_ready, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        id_ready, id_ex_valid;
  logic [31:0] id_ex_npc, id_ex_ir, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm;
  logic [4:0]  id_ex_rd;
  logic [2:0]  id_ex_fmt;

  logic        id_ready_e, id_ex_valid_e;
  logic [31:0] id_ex_npc_e, id_ex_ir_e, id_ex_rs1_val_e, id_ex_rs2_val_e, id_ex_imm_e;
  logic [4:0]  id_ex_rd_e;
  logic [2:0]  id_ex_fmt_e;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .NREGS(32)) u_dut (
    .clk(clk), .reset(reset), .if_id_valid(if_id_valid), .if_id_ir(if_id_ir),
    .if_id_npc(if_id_npc), .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .id_ex_valid(id_ex_valid),
    .id_ex_npc(id_ex_npc), .id_ex_ir(id_ex_ir), .id_ex_rs1_val(id_ex_rs1_val),
    .id_ex_rs2_val(id_ex_rs2_val), .id_ex_imm(id_ex_imm), .id_ex_rd(id_ex_rd),
    .id_ex_fmt(id_ex_fmt)
  );

  decode_stage #(.XLEN(32), .NREGS(16)) u_dut_e (
    .clk(clk), .reset(reset), .if_id_valid(if_id_valid), .if_id_ir(if_id_ir),
    .if_id_npc(if_id_npc), .id_ready(id_ready_e), .flush(flush), .ex_ready(ex_ready),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .id_ex_valid(id_ex_valid_e),
    .id_ex_npc(id_ex_npc_e), .id_ex_ir(id_ex_ir_e), .id_ex_rs1_val(id_ex_rs1_val_e),
    .id_ex_rs2_val(id_ex_rs2_val_e), .id_ex_imm(id_ex_imm_e), .id_ex_rd(id_ex_rd_e),
    .id_ex_fmt(id_ex_fmt_e)
  );

  // Behavioural model of the ID/EX bundle and architectural registers
  logic        m_valid;
  logic [31:0] m_npc, m_ir, m_rs1, m_rs2, m_imm, m_rs1e, m_rs2e;
  logic [4:0]  m_rd;
  logic [2:0]  m_fmt;
  logic [31:0] m_regs [32];
  logic        ready_seen;

`ifdef ID_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int fmt_of(input logic [6:0] op);
    case (op)
      7'b0110011:                                     return 0;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: return 1;
      7'b0100011:                                     return 2;
      7'b1100011:                                     return 3;
      7'b0110111, 7'b0010111:                         return 4;
      7'b1101111:                                     return 5;
      default:                                        return 6;
    endcase
  endfunction

  function automatic logic [31:0] sext(input longint v, input int bits);
    longint r;
    r = v;
    if (r >= (longint'(1) << (bits - 1))) r = r - (longint'(1) << bits);
    return 32'(r);
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] ir);
    longint x;
    x = longint'(ir);
    case (fmt_of(ir[6:0]))
      1: return sext(x >> 20, 12);
      2: return sext(((x >> 25) << 5) + ((x >> 7) & 31), 12);
      3: return sext(((x >> 31) & 1) * 4096 + ((x >> 7) & 1) * 2048 +
                     ((x >> 25) & 63) * 32 + ((x >> 8) & 15) * 2, 13);
      4: return ir & 32'hFFFF_F000;
      5: return sext(((x >> 31) & 1) * 1048576 + ((x >> 12) & 255) * 4096 +
                     ((x >> 20) & 1) * 2048 + ((x >> 21) & 1023) * 2, 21);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] read_model(input logic [4:0] idx, input int n);
    if (idx == 0 || int'(idx) >= n) return 32'h0;
    if (BYPASS && wb_we && wb_rd == idx) return wb_data;
    return m_regs[idx];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_npc = '0; m_ir = '0; m_rs1 = '0; m_rs2 = '0;
    m_imm = '0; m_rd = '0; m_fmt = '0; m_rs1e = '0; m_rs2e = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  endtask

  task automatic check_reset_outputs();
    check_val("rst_valid", 32'(id_ex_valid), 32'h0);
    check_val("rst_npc",   id_ex_npc,        32'h0);
    check_val("rst_ir",    id_ex_ir,         32'h0);
    check_val("rst_rs1",   id_ex_rs1_val,    32'h0);
    check_val("rst_rs2",   id_ex_rs2_val,    32'h0);
    check_val("rst_imm",   id_ex_imm,        32'h0);
    check_val("rst_rd",    32'(id_ex_rd),    32'h0);
    check_val("rst_fmt",   32'(id_ex_fmt),   32'h0);
    check_val("rst_valid_e", 32'(id_ex_valid_e), 32'h0);
  endtask

  task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] npc);
    if_id_valid = v;
    if_id_ir    = ir;
    if_id_npc   = npc;
  endtask

  // Called at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic step();
    logic [4:0]  rs1, rs2;
    logic        hz, adv, rdy, n_valid;
    logic [31:0] n_rs1, n_rs2, n_rs1e, n_rs2e;
    #1;
    rs1 = if_id_ir[19:15];
    rs2 = if_id_ir[24:20];
    hz  = m_valid && (m_ir[6:0] == 7'b0000011) && (m_rd != 0) &&
          ((m_rd == rs1) || (m_rd == rs2)) && if_id_valid;
    adv = ex_ready || !m_valid;
    rdy = flush || (adv && !hz);
    ready_seen = id_ready;
    check_val("id_ready", 32'(id_ready), 32'(rdy));
    check_val("id_ready_e", 32'(id_ready_e), 32'(rdy));
    n_rs1  = read_model(rs1, 32);
    n_rs2  = read_model(rs2, 32);
    n_rs1e = read_model(rs1, 16);
    n_rs2e = read_model(rs2, 16);
    n_valid = m_valid;
    @(posedge clk);
    if (flush) n_valid = 1'b0;
    else if (adv) begin
      if (if_id_valid && !hz) begin
        n_valid = 1'b1;
        m_npc = if_id_npc; m_ir = if_id_ir; m_rd = if_id_ir[11:7];
        m_fmt = 3'(fmt_of(if_id_ir[6:0])); m_imm = imm_of(if_id_ir);
        m_rs1 = n_rs1; m_rs2 = n_rs2; m_rs1e = n_rs1e; m_rs2e = n_rs2e;
      end else n_valid = 1'b0;
    end
    m_valid = n_valid;
    if (wb_we && wb_rd != 0) m_regs[wb_rd] = wb_data;
    #1;
    check_val("valid", 32'(id_ex_valid), 32'(m_valid));
    check_val("valid_e", 32'(id_ex_valid_e), 32'(m_valid));
    if (m_valid) begin
      check_val("npc", id_ex_npc, m_npc);
      check_val("ir",  id_ex_ir,  m_ir);
      check_val("rs1", id_ex_rs1_val, m_rs1);
      check_val("rs2", id_ex_rs2_val, m_rs2);
      check_val("imm", id_ex_imm, m_imm);
      check_val("rd",  32'(id_ex_rd),  32'(m_rd));
      check_val("fmt", 32'(id_ex_fmt), 32'(m_fmt));
      check_val("rs1_e", id_ex_rs1_val_e, m_rs1e);
      check_val("rs2_e", id_ex_rs2_val_e, m_rs2e);
    end
    $display("[TB] v=%0b ir=%h fl=%0b exr=%0b we=%0b rd=%0d -> rdy=%0b id_ex_valid=%0b ir=%h imm=%h",
             if_id_valid, if_id_ir, flush, ex_ready, wb_we, wb_rd, ready_seen,
             id_ex_valid, id_ex_ir, id_ex_imm);
  endtask

  task automatic random_inputs();
    logic [6:0] ops [11];
    logic [31:0] ir;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0000011, 7'b1100111, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111};
    ir = $urandom;
    if ($urandom_range(0, 1) == 1) begin
      ir[11:7]  = 5'($urandom_range(0, 3));
      ir[19:15] = 5'($urandom_range(0, 3));
      ir[24:20] = 5'($urandom_range(0, 3));
    end
    ir[6:0] = ops[$urandom_range(0, 10)];
    drive($urandom_range(0, 3) != 0, ir, $urandom);
    flush    = ($urandom_range(0, 15) == 0);
    ex_ready = ($urandom_range(0, 3) != 0);
    wb_we    = ($urandom_range(0, 1) == 1);
    wb_rd    = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
    wb_data  = $urandom;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    flush = 1'b0; ex_ready = 1'b1; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    ready_seen = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    @(posedge clk); #1;
    reset = 1'b1;

    // addi x1,x0,-1 then beq x0,x0,-4
    drive(1'b1, 32'hFFF00093, 32'h0000_0104);
    step();
    check_val("t2_imm", id_ex_imm, 32'hFFFF_FFFF);
    check_val("t2_fmt", 32'(id_ex_fmt), 32'd1);
    check_val("t2_rd",  32'(id_ex_rd),  32'd1);
    check_val("t2_rs1", id_ex_rs1_val,  32'h0);
    drive(1'b1, 32'hFE000EE3, 32'h0000_0108);
    step();
    check_val("t2_b_imm", id_ex_imm, 32'hFFFF_FFFC);
    check_val("t2_b_fmt", 32'(id_ex_fmt), 32'd3);

    // lw x5 followed by add x6,x5,x5: one bubble
    drive(1'b1, 32'h00002283, 32'h0000_010C);
    step();
    drive(1'b1, 32'h00528333, 32'h0000_0110);
    step();
    check_val("t3_stall_ready", 32'(ready_seen), 32'd0);
    check_val("t3_bubble", 32'(id_ex_valid), 32'd0);
    step();
    check_val("t3_resume_ready", 32'(ready_seen), 32'd1);
    check_val("t3_add_ir", id_ex_ir, 32'h00528333);
    // lw x0 never stalls
    drive(1'b1, 32'h00002003, 32'h0000_0114);
    step();
    drive(1'b1, 32'h00000333, 32'h0000_0118);
    step();
    check_val("t3_x0_ready", 32'(ready_seen), 32'd1);
    check_val("t3_x0_valid", 32'(id_ex_valid), 32'd1);

    // EX stalls for three cycles, then a flush during the hold
    ex_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h0000_011C);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("t4_hold_ready", 32'(ready_seen), 32'd0);
      check_val("t4_hold_ir", id_ex_ir, 32'h00000333);
    end
    flush = 1'b1;
    step();
    check_val("t4_flush_ready", 32'(ready_seen), 32'd1);
    check_val("t4_flush_valid", 32'(id_ex_valid), 32'd0);
    flush = 1'b0; ex_ready = 1'b1;

    // Same-cycle writeback to x3 read by addi x1,x3,0
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    drive(1'b1, 32'h00018093, 32'h0000_0120);
    step();
    check_val("t5_same_cycle", id_ex_rs1_val, BYPASS ? 32'hDEADBEEF : 32'h0);
    wb_we = 1'b0;
    step();
    check_val("t5_next_cycle", id_ex_rs1_val, 32'hDEADBEEF);
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234_5678;
    drive(1'b1, 32'h00000093, 32'h0000_0124);
    step();
    wb_we = 1'b0;
    step();
    check_val("t5_x0", id_ex_rs1_val, 32'h0);

    // x20 exists only in the 32-register instance
    wb_we = 1'b1; wb_rd = 5'd20; wb_data = 32'h0000_0055;
    drive(1'b1, 32'h000A0093, 32'h0000_0128);
    step();
    wb_we = 1'b0;
    step();
    check_val("t6_x20_main", id_ex_rs1_val, 32'h0000_0055);
    check_val("t6_x20_rv32e", id_ex_rs1_val_e, 32'h0);

    for (int i = 0; i < 1200; i++) begin
      random_inputs();
      step();
    end

    // Asynchronous reset while the bundle is valid
    flush = 1'b0; ex_ready = 1'b1; wb_we = 1'b0;
    drive(1'b1, 32'hFFF00093, 32'h0000_0200);
    step();
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      random_inputs();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
